// File: rtl/or1200_ifetch_wb.sv
// ---------------------------------------------------------------------------
// or1200_ifetch_wb
//
// Non-cached instruction-fetch responder. Each fetch-stage request becomes
// one single-beat classic Wishbone read (or no bus cycle at all when the IMMU
// already flagged a fault). Data, ack/err and a 4-bit tag go back to the
// fetch stage through the instruction port.
//
// Parameters
//   RTY_LIMIT  rty terminations tolerated per fetch; the RTY_LIMIT-th one is
//              reported as a bus error
//   TIMEOUT    BUS cycles without any termination before a bus error
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   icpu_adr_i          fetch address (bits [1:0] ignored)
//   icpu_cycstb_i       fetch request, held until ack/err or withdrawn
//   icpu_sel_i          byte selects forwarded to the bus
//   immu_tlbmiss_i      ITLB miss for the current request
//   immu_pagefault_i    IMMU page fault for the current request
//   icpu_dat_o          fetched instruction (l.nop on error)
//   icpu_ack_o          one-cycle fetch-complete pulse
//   icpu_err_o          one-cycle fetch-error pulse
//   icpu_adr_o          word-aligned address of the response
//   icpu_tag_o          response tag (0 idle, 1 insn, b bus err, c pf, d tlb)
//   iwb_*               Wishbone master (classic, read-only)
// ---------------------------------------------------------------------------
module or1200_ifetch_wb #(
  parameter int unsigned RTY_LIMIT = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] icpu_adr_i,
  input  logic        icpu_cycstb_i,
  input  logic [3:0]  icpu_sel_i,
  input  logic        immu_tlbmiss_i,
  input  logic        immu_pagefault_i,
  output logic [31:0] icpu_dat_o,
  output logic        icpu_ack_o,
  output logic        icpu_err_o,
  output logic [31:0] icpu_adr_o,
  output logic [3:0]  icpu_tag_o,
  output logic [31:0] iwb_adr_o,
  output logic        iwb_cyc_o,
  output logic        iwb_stb_o,
  output logic        iwb_we_o,
  output logic [3:0]  iwb_sel_o,
  output logic [2:0]  iwb_cti_o,
  output logic [1:0]  iwb_bte_o,
  input  logic [31:0] iwb_dat_i,
  input  logic        iwb_ack_i,
  input  logic        iwb_err_i,
  input  logic        iwb_rty_i
);

  localparam int unsigned RTY_W = (RTY_LIMIT < 1) ? 1 : $clog2(RTY_LIMIT + 1);
  localparam int unsigned TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(RTY_LIMIT);
  localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);
  localparam logic [RTY_W-1:0] RTY_ZERO = {RTY_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};

  // l.nop, returned as instruction data on every error response
  localparam logic [31:0] NOP_INSN = 32'h1441_0000;

  localparam logic [3:0] TAG_IDLE = 4'h0;
  localparam logic [3:0] TAG_INSN = 4'h1;
  localparam logic [3:0] TAG_BERR = 4'hb;
  localparam logic [3:0] TAG_PF   = 4'hc;
  localparam logic [3:0] TAG_TLB  = 4'hd;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FAULT = 3'd1,
    ST_BUS   = 3'd2,
    ST_RETRY = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // TLB miss outranks a page fault when both are flagged together.
  function automatic logic [3:0] fault_tag(input logic tlbmiss, input logic pagefault);
    logic [3:0] tag;
    if (tlbmiss) begin
      tag = TAG_TLB;
    end else if (pagefault) begin
      tag = TAG_PF;
    end else begin
      tag = TAG_IDLE;
    end
    return tag;
  endfunction

  state_e           state_r,   state_nxt_s;
  logic [31:0]      adr_r,     adr_nxt_s;
  logic [3:0]       sel_r,     sel_nxt_s;
  logic [31:0]      dat_r,     dat_nxt_s;
  logic [3:0]       tag_r,     tag_nxt_s;
  logic             ok_r,      ok_nxt_s;
  logic [RTY_W-1:0] rty_cnt_r, rty_nxt_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_nxt_s;
  logic             cyc_r,     cyc_nxt_s;

  logic             abort_s;
  logic             done_s;
  logic [RTY_W-1:0] rty_inc_s;
  logic [TMO_W-1:0] tmo_inc_s;
  logic             unused_adr_s;

  // Byte offset inside the word has no meaning for instruction fetch.
  assign unused_adr_s = ^icpu_adr_i[1:0];

  // The request is abandoned when the fetch stage withdraws or redirects.
  assign abort_s   = ~icpu_cycstb_i | (icpu_adr_i[31:2] != adr_r[31:2]);
  assign rty_inc_s = rty_cnt_r + RTY_ONE;
  assign tmo_inc_s = tmo_cnt_r + TMO_ONE;
  assign done_s    = (state_r == ST_DONE);

  // Next-state and response-latch decode.
  always_comb begin
    state_nxt_s = state_r;
    adr_nxt_s   = adr_r;
    sel_nxt_s   = sel_r;
    dat_nxt_s   = dat_r;
    tag_nxt_s   = tag_r;
    ok_nxt_s    = ok_r;
    rty_nxt_s   = rty_cnt_r;
    tmo_nxt_s   = tmo_cnt_r;

    case (state_r)
      ST_IDLE: begin
        rty_nxt_s = RTY_ZERO;
        tmo_nxt_s = TMO_ZERO;
        tag_nxt_s = TAG_IDLE;
        if (icpu_cycstb_i) begin
          adr_nxt_s = {icpu_adr_i[31:2], 2'b00};
          sel_nxt_s = icpu_sel_i;
          if (immu_tlbmiss_i | immu_pagefault_i) begin
            // Translation failed: answer without touching the bus.
            tag_nxt_s   = fault_tag(immu_tlbmiss_i, immu_pagefault_i);
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_BUS;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_FAULT: begin
        ok_nxt_s    = 1'b0;
        dat_nxt_s   = NOP_INSN;
        state_nxt_s = ST_DONE;
      end

      ST_BUS: begin
        if (abort_s) begin
          // Any termination seen together with the abort is discarded.
          rty_nxt_s   = RTY_ZERO;
          tmo_nxt_s   = TMO_ZERO;
          state_nxt_s = ST_IDLE;
        end else if (iwb_err_i) begin
          ok_nxt_s    = 1'b0;
          dat_nxt_s   = NOP_INSN;
          tag_nxt_s   = TAG_BERR;
          state_nxt_s = ST_DONE;
        end else if (iwb_ack_i) begin
          ok_nxt_s    = 1'b1;
          dat_nxt_s   = iwb_dat_i;
          tag_nxt_s   = TAG_INSN;
          state_nxt_s = ST_DONE;
        end else if (iwb_rty_i) begin
          if (rty_inc_s == RTY_MAX) begin
            ok_nxt_s    = 1'b0;
            dat_nxt_s   = NOP_INSN;
            tag_nxt_s   = TAG_BERR;
            state_nxt_s = ST_DONE;
          end else begin
            rty_nxt_s   = rty_inc_s;
            state_nxt_s = ST_RETRY;
          end
        end else if (tmo_inc_s == TMO_MAX) begin
          ok_nxt_s    = 1'b0;
          dat_nxt_s   = NOP_INSN;
          tag_nxt_s   = TAG_BERR;
          state_nxt_s = ST_DONE;
        end else begin
          tmo_nxt_s   = tmo_inc_s;
          state_nxt_s = ST_BUS;
        end
      end

      ST_RETRY: begin
        // One idle bus cycle between attempts; the timeout restarts.
        tmo_nxt_s = TMO_ZERO;
        if (abort_s) begin
          rty_nxt_s   = RTY_ZERO;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUS;
        end
      end

      ST_DONE: begin
        rty_nxt_s   = RTY_ZERO;
        tmo_nxt_s   = TMO_ZERO;
        tag_nxt_s   = TAG_IDLE;
        state_nxt_s = ST_IDLE;
      end

      default: begin
        rty_nxt_s   = RTY_ZERO;
        tmo_nxt_s   = TMO_ZERO;
        tag_nxt_s   = TAG_IDLE;
        state_nxt_s = ST_IDLE;
      end
    endcase

    // cyc/stb come straight from a flop, so they are decoded one cycle ahead.
    cyc_nxt_s = (state_nxt_s == ST_BUS);
  end

  // State, bus-request and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      adr_r     <= 32'h0000_0000;
      sel_r     <= 4'h0;
      dat_r     <= NOP_INSN;
      tag_r     <= TAG_IDLE;
      ok_r      <= 1'b0;
      rty_cnt_r <= RTY_ZERO;
      tmo_cnt_r <= TMO_ZERO;
      cyc_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      adr_r     <= adr_nxt_s;
      sel_r     <= sel_nxt_s;
      dat_r     <= dat_nxt_s;
      tag_r     <= tag_nxt_s;
      ok_r      <= ok_nxt_s;
      rty_cnt_r <= rty_nxt_s;
      tmo_cnt_r <= tmo_nxt_s;
      cyc_r     <= cyc_nxt_s;
    end
  end

  // A response is only delivered while the fetch stage still asks for it.
  assign icpu_ack_o = done_s &  ok_r & icpu_cycstb_i;
  assign icpu_err_o = done_s & ~ok_r & icpu_cycstb_i;
  assign icpu_dat_o = dat_r;
  assign icpu_adr_o = adr_r;
  assign icpu_tag_o = tag_r;

  assign iwb_adr_o  = adr_r;
  assign iwb_sel_o  = sel_r;
  assign iwb_cyc_o  = cyc_r;
  assign iwb_stb_o  = cyc_r;
  assign iwb_we_o   = 1'b0;
  assign iwb_cti_o  = 3'b000;
  assign iwb_bte_o  = 2'b00;

endmodule

// File: doc/or1200_ifetch_wb.md
# or1200_ifetch_wb

Instruction-fetch responder that services the CPU fetch stage's instruction-port requests by issuing single-beat Wishbone reads. It returns data, ack/err and a 4-bit instruction tag on the same instruction interface the fetch stage consumes. It sits between the CPU core's instruction port and the instruction Wishbone bus, and serves as the non-cached fetch path. It handles immu faults without a bus cycle, bus errors, retries, timeouts and request aborts or redirects.

## Interface
- RTY_LIMIT, 4: consecutive iwb_rty_i terminations tolerated before the fetch is reported as a bus error.
- TIMEOUT, 255: BUS-state cycles without ack/err/rty before the fetch is reported as a bus error. Counter width is clog2(TIMEOUT+1).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- icpu_adr_i  in  32  fetch address; bits [1:0] ignored.
- icpu_cycstb_i  in  1  fetch request, held until ack/err or withdrawn.
- icpu_sel_i  in  4  byte selects, passed to iwb_sel_o.
- immu_tlbmiss_i  in  1  ITLB miss for icpu_adr_i, valid with icpu_cycstb_i.
- immu_pagefault_i  in  1  IMMU page fault, valid with icpu_cycstb_i.
- icpu_dat_o  out  32  fetched instruction.
- icpu_ack_o  out  1  one-cycle fetch-complete pulse.
- icpu_err_o  out  1  one-cycle fetch-error pulse.
- icpu_adr_o  out  32  word-aligned address of the response.
- icpu_tag_o  out  4  response tag: 4'h0 idle, 4'h1 normal instruction, 4'hb bus error, 4'hc page fault, 4'hd TLB miss.
- iwb_adr_o  out  32  Wishbone address, word-aligned.
- iwb_cyc_o, iwb_stb_o  out  1  Wishbone cycle/strobe, registered.
- iwb_we_o  out  1  constant 0.
- iwb_sel_o  out  4  byte selects.
- iwb_cti_o  out  3  constant 3'b000 (classic).
- iwb_bte_o  out  2  constant 2'b00.
- iwb_dat_i  in  32  read data.
- iwb_ack_i, iwb_err_i, iwb_rty_i  in  1  Wishbone terminations.

## Operation
- FSM states: IDLE, FAULT, BUS, RETRY, DONE.
- IDLE:
  - On cycstb with tlbmiss or pagefault, go to FAULT. Tag is 4'hd, or 4'hc if only pagefault; TLB miss has priority. No bus cycle is issued.
  - On cycstb without a fault, latch {adr[31:2],2'b00} and sel, then go to BUS.
- FAULT: latch err response, go to DONE.
- BUS:
  - cyc = stb = 1.
  - iwb_ack_i: latch iwb_dat_i with tag 4'h1, go to DONE.
  - iwb_err_i: tag 4'hb, go to DONE.
  - iwb_rty_i: increment retry count, go to RETRY. If the count reaches RTY_LIMIT, take the err path with tag 4'hb instead.
  - Timeout counter reaches TIMEOUT: err with tag 4'hb, go to DONE.
  - Simultaneous terminations: priority is err > ack > rty.
- RETRY: cyc = stb = 0 for exactly one cycle, then return to BUS. The retry count persists; the timeout counter clears.
- Abort: in BUS or RETRY, if cycstb is low or adr[31:2] differs from the latched address, drop cyc/stb on the next edge and go to IDLE. No response is issued. Any termination arriving in that same cycle is discarded.
- DONE:
  - icpu_ack_o (success) or icpu_err_o (error) equals the latched flag gated by icpu_cycstb_i. If cycstb is low, the response is dropped.
  - Always go to IDLE next cycle.
  - Retry and timeout counters clear on entry to IDLE.
- Output data and address:
  - icpu_dat_o = latched data on ack, 32'h1441_0000 (l.nop) on err.
  - icpu_adr_o = latched address.
- Invariants:
  - ack and err are never both high.
  - cyc equals stb.
  - iwb_adr_o and iwb_sel_o are stable while cyc = 1.

## Timing
- Reset (rst = 0, asynchronous) forces:
  - state IDLE; cyc, stb, ack, err = 0.
  - icpu_tag_o = 4'h0; icpu_dat_o = 32'h1441_0000.
  - icpu_adr_o, iwb_adr_o = 0; iwb_sel_o = 0; all counters = 0.
- Reset asserted mid-cycle drops cyc in the same instant.
- Latency, zero-wait bus:
  - Request seen at edge N.
  - cyc/stb high from N+1; ack sampled at N+1.
  - icpu_ack_o high during cycle N+2.
- Fault latency: request at edge N, err in cycle N+2.
- Each retry adds 2 cycles.
- Throughput: at most one response per 3 cycles. The next request is accepted in the IDLE cycle after DONE.

## Test plan
- Zero-wait read, adr 0x0000_1004, iwb_dat_i 0xA5A5_0001 -> cyc for 1 cycle; icpu_ack_o pulse 2 cycles after request with dat 0xA5A5_0001, adr 0x0000_1004, tag 4'h1.
- Address 0x0000_2003 with tlbmiss and pagefault both set -> no cyc; icpu_err_o pulse with tag 4'hd, dat 0x1441_0000, adr 0x0000_2000.
- Slave returns rty 4 times, RTY_LIMIT = 4 -> 4 bus cycles each separated by a 1-cycle stb gap, then err with tag 4'hb; counters are 0 afterward.
- Slave silent, TIMEOUT = 255 -> cyc drops after 255 BUS cycles; err with tag 4'hb.
- Address changes 0x100 -> 0x200 while in BUS, ack arrives in the same cycle -> no icpu response for 0x100; new read at 0x200 acked with its data.
- rst asserted while cyc = 1 -> cyc, stb and all outputs take their reset values immediately; a normal fetch after release completes.
